capi_psl_afu: RTL and testbench

- Minimal CAPI PSL accelerator function unit (AFU), clocked by the PSL clock and driven directly by the PSL-side shell.
- Handles job control (RESET/START) and answers MMIO accesses.
- On START it issues one cache-line read of the work element descriptor (WED) address and captures the first 64 bits of returned data.
- It then completes the job, reporting the PSL response code as the job error.

---
 rtl/capi_psl_afu.sv | 212 +++++++++++++++++++++
 tb/tb_capi_psl_afu.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capi_psl_afu.sv
// Minimal CAPI PSL AFU: job control, one WED cache-line read, and a small MMIO space.
// PSL buses use big-endian bit numbering (bit 0 = MSB). Ports are declared [W-1:0], so
// PSL bit k of a W-bit field is index W-1-k here (e.g. ha_bwdata[0:63] is ha_bwdata[511:448]).
module capi_psl_afu #(
    parameter logic [7:0] CMD_TAG = 8'h00,
    parameter logic [3:0] BR_LAT  = 4'd1
) (
    input  logic         ha_pclock,
    input  logic         ha_reset,
    // Command
    output logic         ah_cvalid,
    output logic [7:0]   ah_ctag,
    output logic         ah_ctagpar,
    output logic [12:0]  ah_com,
    output logic         ah_compar,
    output logic [2:0]   ah_cabt,
    output logic [63:0]  ah_cea,
    output logic         ah_ceapar,
    output logic [15:0]  ah_cch,
    output logic [11:0]  ah_csize,
    input  logic [7:0]   ha_croom,
    // Buffer read
    input  logic         ha_brvalid,
    input  logic [7:0]   ha_brtag,
    input  logic         ha_brtagpar,
    input  logic [5:0]   ha_brad,
    output logic [3:0]   ah_brlat,
    output logic [511:0] ah_brdata,
    output logic [7:0]   ah_brpar,
    // Buffer write
    input  logic         ha_bwvalid,
    input  logic [7:0]   ha_bwtag,
    input  logic         ha_bwtagpar,
    input  logic [5:0]   ha_bwad,
    input  logic [511:0] ha_bwdata,
    input  logic [7:0]   ha_bwpar,
    // Response
    input  logic         ha_rvalid,
    input  logic [7:0]   ha_rtag,
    input  logic         ha_rtagpar,
    input  logic [7:0]   ha_response,
    input  logic [8:0]   ha_rcredits,
    input  logic [1:0]   ha_rcachestate,
    input  logic [12:0]  ha_rcachepos,
    // MMIO
    input  logic         ha_mmval,
    input  logic         ha_mmcfg,
    input  logic         ha_mmrnw,
    input  logic         ha_mmdw,
    input  logic [23:0]  ha_mmad,
    input  logic         ha_mmadpar,
    input  logic [63:0]  ha_mmdata,
    input  logic         ha_mmdatapar,
    output logic         ah_mmack,
    output logic [63:0]  ah_mmdata,
    output logic         ah_mmdatapar,
    // Control
    input  logic         ha_jval,
    input  logic [7:0]   ha_jcom,
    input  logic         ha_jcompar,
    input  logic [63:0]  ha_jea,
    input  logic         ha_jeapar,
    output logic         ah_jrunning,
    output logic         ah_jdone,
    output logic         ah_jcack,
    output logic [63:0]  ah_jerror,
    output logic         ah_jyield,
    output logic         ah_tbreq,
    output logic         ah_paren
);

    localparam logic [7:0]  JCOM_RESET = 8'h80;
    localparam logic [7:0]  JCOM_START = 8'h90;
    localparam logic [12:0] COM_READ_CL_NA = 13'h0A00;

    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

    state_t      state_q;
    logic [63:0] wed_q;
    logic [63:0] qword_q;
    logic [63:0] scratch_q;
    logic        job_reset;
    logic        job_start;
    logic [22:0] mm_reg;
    logic        mm_lower;
    logic [63:0] mm_rdata;

    assign job_reset = ha_jval && (ha_jcom == JCOM_RESET);
    assign job_start = ha_jval && (ha_jcom == JCOM_START);

    // PSL mmad[0:22] is the doubleword register index, mmad[23] picks the word half.
    assign mm_reg   = ha_mmad[23:1];
    assign mm_lower = ha_mmad[0];

    // Constant command fields and tied-off interfaces
    assign ah_ctag    = CMD_TAG;
    assign ah_ctagpar = ~^CMD_TAG;
    assign ah_com     = COM_READ_CL_NA;
    assign ah_compar  = ~^COM_READ_CL_NA;
    assign ah_cabt    = 3'b000;
    assign ah_cea     = wed_q;
    assign ah_ceapar  = ~^wed_q;
    assign ah_cch     = 16'h0000;
    assign ah_csize   = 12'd128;
    assign ah_brlat   = BR_LAT;
    assign ah_brdata  = '0;
    assign ah_brpar   = 8'hFF;
    assign ah_jcack   = 1'b0;
    assign ah_jyield  = 1'b0;
    assign ah_tbreq   = 1'b0;
    assign ah_paren   = 1'b0;
    assign ah_mmdatapar = ~^ah_mmdata;

    // MMIO read mux; word reads replicate the selected half on both halves
    always_comb begin
        mm_rdata = 64'h0;
        if (!ha_mmcfg) begin
            if (ha_mmdw) begin
                if (mm_reg == 23'd0) begin
                    mm_rdata = qword_q;
                end else if (mm_reg == 23'd1) begin
                    mm_rdata = scratch_q;
                end
            end else begin
                if (mm_reg == 23'd0) begin
                    mm_rdata = mm_lower ? {2{qword_q[31:0]}} : {2{qword_q[63:32]}};
                end else if (mm_reg == 23'd1) begin
                    mm_rdata = mm_lower ? {2{scratch_q[31:0]}} : {2{scratch_q[63:32]}};
                end
            end
        end
    end

    // Job FSM: START -> issue one read -> wait for data/response -> done pulse
    always_ff @(posedge ha_pclock) begin
        if (ha_reset || job_reset) begin
            state_q     <= IDLE;
            wed_q       <= 64'h0;
            qword_q     <= 64'h0;
            ah_cvalid   <= 1'b0;
            ah_jrunning <= 1'b0;
            ah_jerror   <= 64'h0;
            // Only the RESET job command is acknowledged with jdone
            ah_jdone    <= !ha_reset;
        end else begin
            ah_cvalid <= 1'b0;
            ah_jdone  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (job_start) begin
                        wed_q       <= ha_jea;
                        ah_jrunning <= 1'b1;
                        ah_jerror   <= 64'h0;
                        state_q     <= CMD;
                    end
                end
                CMD: begin
                    if (ha_croom != 8'd0) begin
                        ah_cvalid <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // Data capture and completion may coincide; both take effect this edge
                    if (ha_bwvalid && (ha_bwtag == CMD_TAG) && !ha_bwad[0]) begin
                        qword_q <= ha_bwdata[511:448];
                    end
                    if (ha_rvalid && (ha_rtag == CMD_TAG)) begin
                        ah_jerror <= {56'h0, ha_response};
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    ah_jdone    <= 1'b1;
                    ah_jrunning <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // MMIO: one-cycle ack, registered read data held between acks, scratch writes
    always_ff @(posedge ha_pclock) begin
        if (ha_reset || job_reset) begin
            ah_mmack  <= 1'b0;
            ah_mmdata <= 64'h0;
            scratch_q <= 64'h0;
        end else begin
            ah_mmack <= ha_mmval;
            if (ha_mmval && ha_mmrnw) begin
                ah_mmdata <= mm_rdata;
            end
            if (ha_mmval && !ha_mmrnw && !ha_mmcfg && (mm_reg == 23'd1)) begin
                if (ha_mmdw) begin
                    scratch_q <= ha_mmdata;
                end else if (mm_lower) begin
                    scratch_q[31:0] <= ha_mmdata[31:0];
                end else begin
                    scratch_q[63:32] <= ha_mmdata[63:32];
                end
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{ha_brvalid, ha_brtag, ha_brtagpar, ha_brad, ha_bwtagpar,
                             ha_bwad[5:1], ha_bwdata[447:0], ha_bwpar, ha_rtagpar,
                             ha_rcredits, ha_rcachestate, ha_rcachepos, ha_mmadpar,
                             ha_mmdatapar, ha_jcompar, ha_jeapar};

endmodule

// File: tb/tb_capi_psl_afu.sv
// Directed bench for capi_psl_afu: reset, job flow, command credit stall, MMIO.
module tb_capi_psl_afu;

    logic         ha_pclock = 1'b0;
    logic         ha_reset;
    logic         ah_cvalid;
    logic [7:0]   ah_ctag;
    logic         ah_ctagpar;
    logic [12:0]  ah_com;
    logic         ah_compar;
    logic [2:0]   ah_cabt;
    logic [63:0]  ah_cea;
    logic         ah_ceapar;
    logic [15:0]  ah_cch;
    logic [11:0]  ah_csize;
    logic [7:0]   ha_croom;
    logic         ha_brvalid;
    logic [7:0]   ha_brtag;
    logic         ha_brtagpar;
    logic [5:0]   ha_brad;
    logic [3:0]   ah_brlat;
    logic [511:0] ah_brdata;
    logic [7:0]   ah_brpar;
    logic         ha_bwvalid;
    logic [7:0]   ha_bwtag;
    logic         ha_bwtagpar;
    logic [5:0]   ha_bwad;
    logic [511:0] ha_bwdata;
    logic [7:0]   ha_bwpar;
    logic         ha_rvalid;
    logic [7:0]   ha_rtag;
    logic         ha_rtagpar;
    logic [7:0]   ha_response;
    logic [8:0]   ha_rcredits;
    logic [1:0]   ha_rcachestate;
    logic [12:0]  ha_rcachepos;
    logic         ha_mmval;
    logic         ha_mmcfg;
    logic         ha_mmrnw;
    logic         ha_mmdw;
    logic [23:0]  ha_mmad;
    logic         ha_mmadpar;
    logic [63:0]  ha_mmdata;
    logic         ha_mmdatapar;
    logic         ah_mmack;
    logic [63:0]  ah_mmdata;
    logic         ah_mmdatapar;
    logic         ha_jval;
    logic [7:0]   ha_jcom;
    logic         ha_jcompar;
    logic [63:0]  ha_jea;
    logic         ha_jeapar;
    logic         ah_jrunning;
    logic         ah_jdone;
    logic         ah_jcack;
    logic [63:0]  ah_jerror;
    logic         ah_jyield;
    logic         ah_tbreq;
    logic         ah_paren;

    int checks = 0;
    int fails  = 0;

    capi_psl_afu dut (
        .ha_pclock(ha_pclock), .ha_reset(ha_reset),
        .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar), .ah_com(ah_com),
        .ah_compar(ah_compar), .ah_cabt(ah_cabt), .ah_cea(ah_cea), .ah_ceapar(ah_ceapar),
        .ah_cch(ah_cch), .ah_csize(ah_csize), .ha_croom(ha_croom),
        .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brtagpar(ha_brtagpar),
        .ha_brad(ha_brad), .ah_brlat(ah_brlat), .ah_brdata(ah_brdata), .ah_brpar(ah_brpar),
        .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwtagpar(ha_bwtagpar),
        .ha_bwad(ha_bwad), .ha_bwdata(ha_bwdata), .ha_bwpar(ha_bwpar),
        .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_rtagpar(ha_rtagpar),
        .ha_response(ha_response), .ha_rcredits(ha_rcredits),
        .ha_rcachestate(ha_rcachestate), .ha_rcachepos(ha_rcachepos),
        .ha_mmval(ha_mmval), .ha_mmcfg(ha_mmcfg), .ha_mmrnw(ha_mmrnw), .ha_mmdw(ha_mmdw),
        .ha_mmad(ha_mmad), .ha_mmadpar(ha_mmadpar), .ha_mmdata(ha_mmdata),
        .ha_mmdatapar(ha_mmdatapar), .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata),
        .ah_mmdatapar(ah_mmdatapar),
        .ha_jval(ha_jval), .ha_jcom(ha_jcom), .ha_jcompar(ha_jcompar), .ha_jea(ha_jea),
        .ha_jeapar(ha_jeapar), .ah_jrunning(ah_jrunning), .ah_jdone(ah_jdone),
        .ah_jcack(ah_jcack), .ah_jerror(ah_jerror), .ah_jyield(ah_jyield),
        .ah_tbreq(ah_tbreq), .ah_paren(ah_paren)
    );

    always #5 ha_pclock = ~ha_pclock;

    // Advance one clock; inputs set afterwards are sampled by the next rising edge
    task automatic tick();
        @(posedge ha_pclock);
        #1;
    endtask

    task automatic mmio(input logic rnw, input logic dw, input logic cfg,
                        input logic [23:0] ad, input logic [63:0] wdata);
        ha_mmval = 1'b1; ha_mmrnw = rnw; ha_mmdw = dw; ha_mmcfg = cfg;
        ha_mmad = ad; ha_mmdata = wdata;
        tick();
        ha_mmval = 1'b0; ha_mmcfg = 1'b0;
    endtask

    task automatic test_reset();
        ha_reset = 1'b1;
        tick();
        tick();
        ha_reset = 1'b0;
        checks++;
        if ({ah_cvalid, ah_jrunning, ah_jdone, ah_mmack} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0000", {ah_cvalid, ah_jrunning, ah_jdone, ah_mmack});
        end
        checks++;
        if (ah_jerror !== 64'h0 || ah_mmdata !== 64'h0 || ah_cea !== 64'h0) begin
            fails++;
            $display("FAIL reset_regs: jerror=%h mmdata=%h cea=%h want 0", ah_jerror, ah_mmdata, ah_cea);
        end
        checks++;
        if (ah_com !== 13'h0A00 || ah_csize !== 12'd128 || ah_ctag !== 8'h00 || ah_cabt !== 3'b000
            || ah_cch !== 16'h0 || ah_brlat !== 4'd1 || ah_brpar !== 8'hFF || ah_brdata !== '0
            || ah_ctagpar !== 1'b1 || ah_compar !== 1'b1) begin
            fails++;
            $display("FAIL constants: com=%h csize=%0d ctag=%h brlat=%0d brpar=%h ctagpar=%b compar=%b",
                     ah_com, ah_csize, ah_ctag, ah_brlat, ah_brpar, ah_ctagpar, ah_compar);
        end
        checks++;
        if ({ah_jcack, ah_jyield, ah_tbreq, ah_paren} !== 4'b0000) begin
            fails++;
            $display("FAIL tied_ctl: got %b want 0000", {ah_jcack, ah_jyield, ah_tbreq, ah_paren});
        end
        tick();
        checks++;
        if (ah_jdone !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_jdone: got %b want 0", ah_jdone);
        end
        // RESET job command: jdone exactly one cycle after jval
        ha_jval = 1'b1; ha_jcom = 8'h80;
        tick();
        ha_jval = 1'b0;
        checks++;
        if (ah_jdone !== 1'b1) begin
            fails++;
            $display("FAIL jreset_jdone: got %b want 1", ah_jdone);
        end
        tick();
        checks++;
        if (ah_jdone !== 1'b0) begin
            fails++;
            $display("FAIL jreset_jdone_len: got %b want 0", ah_jdone);
        end
    endtask

    task automatic test_start_and_complete();
        int ncmd;
        ha_croom = 8'd64;
        ha_jea = 64'h1000; ha_jval = 1'b1; ha_jcom = 8'h90;
        tick();
        ha_jval = 1'b0;
        checks++;
        if (ah_jrunning !== 1'b1 || ah_cvalid !== 1'b0) begin
            fails++;
            $display("FAIL start_running: jrunning=%b cvalid=%b want 1 0", ah_jrunning, ah_cvalid);
        end
        tick();
        checks++;
        if (ah_cvalid !== 1'b1 || ah_com !== 13'h0A00 || ah_cea !== 64'h1000
            || ah_csize !== 12'd128 || ah_ceapar !== 1'b0) begin
            fails++;
            $display("FAIL cmd_issue: cvalid=%b com=%h cea=%h csize=%0d ceapar=%b want 1 0a00 1000 128 0",
                     ah_cvalid, ah_com, ah_cea, ah_csize, ah_ceapar);
        end
        ncmd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ah_cvalid === 1'b1) ncmd++;
        end
        checks++;
        if (ncmd !== 0) begin
            fails++;
            $display("FAIL cmd_single: extra cvalid=%0d want 0", ncmd);
        end
        // Distractors: wrong tag, upper half, then the real first half
        ha_bwvalid = 1'b1; ha_bwtag = 8'h05; ha_bwad = 6'd0; ha_bwdata = '0;
        ha_bwdata[511:448] = 64'h1111_2222_3333_4444;
        tick();
        ha_bwtag = 8'h00; ha_bwad = 6'd1; ha_bwdata[511:448] = 64'h5555_6666_7777_8888;
        tick();
        ha_bwad = 6'd0; ha_bwdata[511:448] = 64'hDEADBEEF_01234567;
        ha_bwdata[447:384] = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        ha_bwvalid = 1'b0;
        ha_rvalid = 1'b1; ha_rtag = 8'h07; ha_response = 8'h09;
        tick();
        ha_rtag = 8'h00; ha_response = 8'h00;
        checks++;
        if (ah_jrunning !== 1'b1 || ah_jdone !== 1'b0) begin
            fails++;
            $display("FAIL wrong_rtag: jrunning=%b jdone=%b want 1 0", ah_jrunning, ah_jdone);
        end
        tick();
        ha_rvalid = 1'b0;
        checks++;
        if (ah_jdone !== 1'b0) begin
            fails++;
            $display("FAIL done_early: jdone=%b want 0", ah_jdone);
        end
        tick();
        checks++;
        if (ah_jdone !== 1'b1 || ah_jrunning !== 1'b0 || ah_jerror !== 64'h0) begin
            fails++;
            $display("FAIL job_done: jdone=%b jrunning=%b jerror=%h want 1 0 0",
                     ah_jdone, ah_jrunning, ah_jerror);
        end
        tick();
        checks++;
        if (ah_jdone !== 1'b0) begin
            fails++;
            $display("FAIL jdone_len: got %b want 0", ah_jdone);
        end
        mmio(1'b1, 1'b1, 1'b0, 24'h000000, 64'h0);
        checks++;
        if (ah_mmack !== 1'b1 || ah_mmdata !== 64'hDEADBEEF_01234567
            || ah_mmdatapar !== ~^(64'hDEADBEEF_01234567)) begin
            fails++;
            $display("FAIL qword_read: ack=%b data=%h par=%b want 1 deadbeef01234567",
                     ah_mmack, ah_mmdata, ah_mmdatapar);
        end
        tick();
        checks++;
        if (ah_mmack !== 1'b0 || ah_mmdata !== 64'hDEADBEEF_01234567) begin
            fails++;
            $display("FAIL mmack_len: ack=%b data=%h want 0 deadbeef01234567", ah_mmack, ah_mmdata);
        end
    endtask

    task automatic test_croom_stall();
        int ncmd;
        logic [63:0] cea_seen;
        ha_croom = 8'd0;
        ha_jea = 64'h2000; ha_jval = 1'b1; ha_jcom = 8'h90;
        tick();
        ha_jcom = 8'h90; ha_jea = 64'h3000;  // START while busy must be ignored
        tick();
        ha_jval = 1'b0;
        ncmd = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ah_cvalid === 1'b1) ncmd++;
        end
        checks++;
        if (ncmd !== 0) begin
            fails++;
            $display("FAIL croom_stall: cvalid count=%0d want 0", ncmd);
        end
        ha_croom = 8'd1;
        ncmd = 0;
        cea_seen = 64'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ah_cvalid === 1'b1) begin
                ncmd++;
                cea_seen = ah_cea;
            end
        end
        checks++;
        if (ncmd !== 1 || cea_seen !== 64'h2000) begin
            fails++;
            $display("FAIL croom_release: count=%0d cea=%h want 1 2000", ncmd, cea_seen);
        end
        // Data and response for our tag in the same cycle
        ha_bwvalid = 1'b1; ha_bwtag = 8'h00; ha_bwad = 6'd0;
        ha_bwdata[511:448] = 64'h1122_3344_5566_7788;
        ha_rvalid = 1'b1; ha_rtag = 8'h00; ha_response = 8'h04;
        tick();
        ha_bwvalid = 1'b0; ha_rvalid = 1'b0;
        tick();
        checks++;
        if (ah_jdone !== 1'b1 || ah_jerror !== 64'h4 || ah_jrunning !== 1'b0) begin
            fails++;
            $display("FAIL err_done: jdone=%b jerror=%h jrunning=%b want 1 4 0",
                     ah_jdone, ah_jerror, ah_jrunning);
        end
        mmio(1'b1, 1'b1, 1'b0, 24'h000000, 64'h0);
        checks++;
        if (ah_mmdata !== 64'h1122_3344_5566_7788 || ah_jerror !== 64'h4) begin
            fails++;
            $display("FAIL simul_capture: data=%h jerror=%h want 1122334455667788 4",
                     ah_mmdata, ah_jerror);
        end
    endtask

    task automatic test_mmio();
        mmio(1'b0, 1'b1, 1'b0, 24'h000002, 64'hA5A5_5A5A_0000_FFFF);
        checks++;
        if (ah_mmack !== 1'b1) begin
            fails++;
            $display("FAIL write_ack: got %b want 1", ah_mmack);
        end
        mmio(1'b1, 1'b1, 1'b0, 24'h000002, 64'h0);
        checks++;
        if (ah_mmdata !== 64'hA5A5_5A5A_0000_FFFF || ah_mmdatapar !== ~^(64'hA5A5_5A5A_0000_FFFF)) begin
            fails++;
            $display("FAIL scratch_dw: got %h par %b want a5a55a5a0000ffff", ah_mmdata, ah_mmdatapar);
        end
        mmio(1'b1, 1'b0, 1'b0, 24'h000003, 64'h0);
        checks++;
        if (ah_mmdata !== 64'h0000FFFF_0000FFFF) begin
            fails++;
            $display("FAIL word_lo: got %h want 0000ffff0000ffff", ah_mmdata);
        end
        mmio(1'b1, 1'b0, 1'b0, 24'h000002, 64'h0);
        checks++;
        if (ah_mmdata !== 64'hA5A55A5A_A5A55A5A) begin
            fails++;
            $display("FAIL word_hi: got %h want a5a55a5aa5a55a5a", ah_mmdata);
        end
        mmio(1'b0, 1'b0, 1'b0, 24'h000002, 64'h12345678_12345678);
        mmio(1'b1, 1'b1, 1'b0, 24'h000002, 64'h0);
        checks++;
        if (ah_mmdata !== 64'h12345678_0000FFFF) begin
            fails++;
            $display("FAIL word_write: got %h want 123456780000ffff", ah_mmdata);
        end
        mmio(1'b0, 1'b1, 1'b0, 24'h000000, 64'hFFFF_FFFF_FFFF_FFFF);  // read-only qword
        mmio(1'b1, 1'b1, 1'b0, 24'h000000, 64'h0);
        checks++;
        if (ah_mmdata !== 64'h1122_3344_5566_7788) begin
            fails++;
            $display("FAIL qword_ro: got %h want 1122334455667788", ah_mmdata);
        end
        mmio(1'b1, 1'b1, 1'b1, 24'h000002, 64'h0);
        checks++;
        if (ah_mmack !== 1'b1 || ah_mmdata !== 64'h0 || ah_mmdatapar !== 1'b1) begin
            fails++;
            $display("FAIL cfg_read: ack=%b data=%h par=%b want 1 0 1", ah_mmack, ah_mmdata, ah_mmdatapar);
        end
        mmio(1'b0, 1'b1, 1'b1, 24'h000002, 64'hDEAD_DEAD_DEAD_DEAD);  // cfg write ignored
        mmio(1'b1, 1'b1, 1'b0, 24'h000010, 64'h0);
        checks++;
        if (ah_mmdata !== 64'h0) begin
            fails++;
            $display("FAIL unmapped: got %h want 0", ah_mmdata);
        end
        mmio(1'b1, 1'b1, 1'b0, 24'h000002, 64'h0);
        checks++;
        if (ah_mmdata !== 64'h12345678_0000FFFF) begin
            fails++;
            $display("FAIL cfg_write_ignored: got %h want 123456780000ffff", ah_mmdata);
        end
        // RESET job clears scratch and read data
        ha_jval = 1'b1; ha_jcom = 8'h80;
        tick();
        ha_jval = 1'b0;
        mmio(1'b1, 1'b1, 1'b0, 24'h000002, 64'h0);
        checks++;
        if (ah_mmdata !== 64'h0 || ah_jerror !== 64'h0) begin
            fails++;
            $display("FAIL jreset_clear: scratch=%h jerror=%h want 0 0", ah_mmdata, ah_jerror);
        end
    endtask

    initial begin
        ha_reset = 1'b1; ha_croom = 8'd0;
        ha_brvalid = 1'b0; ha_brtag = 8'h0; ha_brtagpar = 1'b0; ha_brad = 6'd0;
        ha_bwvalid = 1'b0; ha_bwtag = 8'h0; ha_bwtagpar = 1'b0; ha_bwad = 6'd0;
        ha_bwdata = '0; ha_bwpar = 8'h0;
        ha_rvalid = 1'b0; ha_rtag = 8'h0; ha_rtagpar = 1'b0; ha_response = 8'h0;
        ha_rcredits = 9'd0; ha_rcachestate = 2'd0; ha_rcachepos = 13'd0;
        ha_mmval = 1'b0; ha_mmcfg = 1'b0; ha_mmrnw = 1'b0; ha_mmdw = 1'b0;
        ha_mmad = 24'h0; ha_mmadpar = 1'b0; ha_mmdata = 64'h0; ha_mmdatapar = 1'b0;
        ha_jval = 1'b0; ha_jcom = 8'h0; ha_jcompar = 1'b0; ha_jea = 64'h0; ha_jeapar = 1'b0;
        test_reset();
        test_start_and_complete();
        test_croom_stall();
        test_mmio();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
